// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: datapath widths, NOP encoding and the fetch entry
// carried from the prefetch queue into the issue pipe register.
`default_nettype none

package mips_pipe_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buf_ram.sv
// DEPTH x WIDTH register array for the prefetch queue: one synchronous write
// port and one asynchronous read port.
`default_nettype none

module fetch_buf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_buf.sv
// Show-ahead prefetch queue between fetch and issue; buffers {next_seq_pc, instr}.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_BUF_BYPASS_EN.
`default_nettype none

module fetch_prefetch_buf
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = mips_pipe_pkg::PC_W,
  parameter int INSTR_W = mips_pipe_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [PC_W-1:0]          push_pc_i,
  input  logic [INSTR_W-1:0]       push_instr_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [PC_W-1:0]          next_pc_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] rd_data;

  logic stored_valid, bypass, pop_acc, push_acc, wr_en, rd_adv;

  assign stored_valid = (count != '0);

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = !stored_valid && push_i && !flush_i && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign valid_o  = stored_valid || bypass;
  assign pop_acc  = pop_i && valid_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  // A bypassed entry that is popped in the same cycle never touches storage.
  assign wr_en    = push_acc && !(bypass && pop_i) && !flush_i && !reset;
  assign rd_adv   = pop_acc && stored_valid && !flush_i && !reset;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = !stored_valid;
  assign count_o = count;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_adv);
    end
  end

  fetch_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({push_pc_i, push_instr_i}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    next_pc_o = '0;
    instr_o   = INSTR_W'(NOP_INSTR);
    if (stored_valid) begin
      next_pc_o = rd_data[EW-1 -: PC_W];
      instr_o   = rd_data[INSTR_W-1:0];
    end else if (bypass) begin
      next_pc_o = push_pc_i;
      instr_o   = push_instr_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_buf.sv
// Directed self-checking bench for fetch_prefetch_buf (default DEPTH=4).
`default_nettype none

module tb_fetch_prefetch_buf;

  logic        clk = 1'b0;
  logic        reset, flush_i, push_i, pop_i;
  logic [31:0] push_pc_i, push_instr_i;
  logic        valid_o, full_o, empty_o;
  logic [31:0] next_pc_o, instr_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_prefetch_buf dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .push_pc_i    (push_pc_i),
    .push_instr_i (push_instr_i),
    .pop_i        (pop_i),
    .valid_o      (valid_o),
    .next_pc_o    (next_pc_o),
    .instr_o      (instr_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .count_o      (count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic psh, input logic [31:0] pc, input logic [31:0] ins, input logic pp);
    push_i = psh; push_pc_i = pc; push_instr_i = ins; pop_i = pp;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 64'(valid_o), 64'd0);
    check({tag, ".empty"}, 64'(empty_o), 64'd1);
    check({tag, ".full"},  64'(full_o),  64'd0);
    check({tag, ".count"}, 64'(count_o), 64'd0);
    check({tag, ".instr"}, 64'(instr_o), 64'd0);
    check({tag, ".pc"},    64'(next_pc_o), 64'd0);
  endtask

  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  initial begin
    reset = 1'b1; flush_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Fill to full, then an extra push that must be dropped
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'h2008_0001 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("fill.count", 64'(count_o), 64'd4);
    check("fill.full",  64'(full_o),  64'd1);
    check("fill.head",  64'(instr_o), 64'h2008_0001);
    drive(1'b1, 32'd20, 32'h2008_0005, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("drop.count", 64'(count_o), 64'd4);
    check("drop.head",  64'(instr_o), 64'h2008_0001);
    for (int i = 0; i < 4; i++) begin
      check("drain.instr", 64'(instr_o), 64'h2008_0001 + 64'(i));
      check("drain.pc",    64'(next_pc_o), 64'(4 * (i + 1)));
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      #1;
    end
    check("drain.empty", 64'(empty_o), 64'd1);
    check("drain.valid", 64'(valid_o), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    check("popempty.count", 64'(count_o), 64'd0);

    // Simultaneous push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      q_pc.push_back(32'h100 + 32'(4 * i));
      q_ins.push_back(32'hA000_0000 + 32'(i));
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
      tick();
    end
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
      #1;
      check("sim.instr", 64'(instr_o), 64'(q_ins[0]));
      check("sim.pc",    64'(next_pc_o), 64'(q_pc[0]));
      void'(q_pc.pop_front()); void'(q_ins.pop_front());
      q_pc.push_back(push_pc_i); q_ins.push_back(push_instr_i);
      tick();
      check("sim.count", 64'(count_o), 64'd2);
    end
    while (q_ins.size() > 0) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      check("simdrain.instr", 64'(instr_o), 64'(q_ins[0]));
      void'(q_pc.pop_front()); void'(q_ins.pop_front());
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    check("simdrain.empty", 64'(empty_o), 64'd1);

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
      tick();
    end
    check("preflush.count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    drive(1'b1, 32'h2FC, 32'hBEEF_0000, 1'b1);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("flush.count", 64'(count_o), 64'd0);
    check("flush.valid", 64'(valid_o), 64'd0);
    drive(1'b1, 32'h300, 32'hC000_0001, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("postflush.valid", 64'(valid_o), 64'd1);
    check("postflush.instr", 64'(instr_o), 64'hC000_0001);
    check("postflush.pc",    64'(next_pc_o), 64'h300);
    check("postflush.count", 64'(count_o), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    check("postflush.empty", 64'(empty_o), 64'd1);

    // Push+pop into an empty queue
    drive(1'b1, 32'h40, 32'h8C22_0004, 1'b1);
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    check("byp.valid", 64'(valid_o), 64'd1);
    check("byp.instr", 64'(instr_o), 64'h8C22_0004);
    check("byp.pc",    64'(next_pc_o), 64'h40);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("byp.count", 64'(count_o), 64'd0);
    check("byp.valid_after", 64'(valid_o), 64'd0);
`else
    check("byp.valid", 64'(valid_o), 64'd0);
    check("byp.instr", 64'(instr_o), 64'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check("byp.count", 64'(count_o), 64'd1);
    check("byp.head",  64'(instr_o), 64'h8C22_0004);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
`endif

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0);
      tick();
    end
    check("prereset.count", 64'(count_o), 64'd3);
    reset = 1'b1;
    drive(1'b1, 32'h5FC, 32'hDEAD_0000, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    check_reset_state("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
